atm_session_ctrl: RTL

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

---
 rtl/atm_pkg.sv | 28 ++
 rtl/atm_session_ctrl_if.sv | 45 ++++
 rtl/atm_account_bank.sv | 94 +++++++++
 rtl/atm_session_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state, opcode and status encodings for the ATM session controller
package atm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIN,
        S_MENU,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_DEPOSIT  = 3'b000;
    localparam logic [2:0] OP_WITHDRAW = 3'b001;
    localparam logic [2:0] OP_BALANCE  = 3'b010;
    localparam logic [2:0] OP_TRANSFER = 3'b011;
    localparam logic [2:0] OP_EXIT     = 3'b100;

    localparam logic [3:0] RSP_OK           = 4'd0;
    localparam logic [3:0] RSP_NO_ACCOUNT   = 4'd1;
    localparam logic [3:0] RSP_BAD_PIN      = 4'd2;
    localparam logic [3:0] RSP_LOCKED       = 4'd3;
    localparam logic [3:0] RSP_INSUFFICIENT = 4'd4;
    localparam logic [3:0] RSP_BAD_AMOUNT   = 4'd5;
    localparam logic [3:0] RSP_OVERFLOW     = 4'd6;
    localparam logic [3:0] RSP_TIMEOUT      = 4'd7;
    localparam logic [3:0] RSP_BAD_OP       = 4'd8;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - table load, card, PIN, operation and response signals of the session controller
interface atm_session_ctrl_if #(
    parameter int N_ACCT = 4,
    parameter int ID_W   = 12,
    parameter int BAL_W  = 16,
    parameter int AMT_W  = 8
);
    localparam int IDX_W = $clog2(N_ACCT);

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [ID_W-1:0]  cfg_id;
    logic [ID_W-1:0]  cfg_pin;
    logic [BAL_W-1:0] cfg_bal;
    logic             card_valid;
    logic [ID_W-1:0]  card_id;
    logic             pin_valid;
    logic [ID_W-1:0]  pin;
    logic             op_valid;
    logic [2:0]       op;
    logic [AMT_W-1:0] amount;
    logic [ID_W-1:0]  dst_id;
    logic             op_ready;
    logic             rsp_valid;
    logic [3:0]       rsp_status;
    logic [BAL_W-1:0] rsp_balance;
    logic [BAL_W-1:0] rsp_dst_balance;
    logic             session_active;
    logic             locked;

    modport master (
        output cfg_we, cfg_idx, cfg_id, cfg_pin, cfg_bal, card_valid, card_id,
               pin_valid, pin, op_valid, op, amount, dst_id,
        input  op_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance,
               session_active, locked
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_id, cfg_pin, cfg_bal, card_valid, card_id,
               pin_valid, pin, op_valid, op, amount, dst_id,
        output op_ready, rsp_valid, rsp_status, rsp_balance, rsp_dst_balance,
               session_active, locked
    );

endinterface

// File: rtl/atm_account_bank.sv
// rtl/atm_account_bank.sv - account table with two ID lookups, one index read and a dual-entry balance write
module atm_account_bank
    import atm_pkg::*;
#(
    parameter int N_ACCT = 4,
    parameter int ID_W   = 12,
    parameter int BAL_W  = 16,
    localparam int IDX_W = $clog2(N_ACCT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [ID_W-1:0]  cfg_id,
    input  logic [ID_W-1:0]  cfg_pin,
    input  logic [BAL_W-1:0] cfg_bal,
    input  logic             lock_we,
    input  logic [IDX_W-1:0] lock_idx,
    input  logic             wr_a_en,
    input  logic [IDX_W-1:0] wr_a_idx,
    input  logic [BAL_W-1:0] wr_a_bal,
    input  logic             wr_b_en,
    input  logic [IDX_W-1:0] wr_b_idx,
    input  logic [BAL_W-1:0] wr_b_bal,
    input  logic [ID_W-1:0]  lk_a_id,
    output logic             lk_a_hit,
    output logic [IDX_W-1:0] lk_a_idx,
    output logic             lk_a_lock,
    input  logic [ID_W-1:0]  lk_b_id,
    output logic             lk_b_hit,
    output logic [IDX_W-1:0] lk_b_idx,
    output logic [BAL_W-1:0] lk_b_bal,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ID_W-1:0]  rd_pin,
    output logic [BAL_W-1:0] rd_bal
);

    logic [ID_W-1:0]  id_tab  [N_ACCT];
    logic [ID_W-1:0]  pin_tab [N_ACCT];
    logic [BAL_W-1:0] bal_tab [N_ACCT];
    logic [N_ACCT-1:0] valid_tab;
    logic [N_ACCT-1:0] lock_tab;

    // table storage: config load, lock set and the paired balance update
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_ACCT; i++) begin
                id_tab[i]  <= '0;
                pin_tab[i] <= '0;
                bal_tab[i] <= '0;
            end
            valid_tab <= '0;
            lock_tab  <= '0;
        end else begin
            if (cfg_we && (32'(cfg_idx) < N_ACCT)) begin
                id_tab[cfg_idx]    <= cfg_id;
                pin_tab[cfg_idx]   <= cfg_pin;
                bal_tab[cfg_idx]   <= cfg_bal;
                valid_tab[cfg_idx] <= 1'b1;
                lock_tab[cfg_idx]  <= 1'b0;
            end
            if (lock_we)
                lock_tab[lock_idx] <= 1'b1;
            if (wr_a_en)
                bal_tab[wr_a_idx] <= wr_a_bal;
            if (wr_b_en)
                bal_tab[wr_b_idx] <= wr_b_bal;
        end
    end

    // ID lookups scan downward so the lowest matching index is the one kept
    always_comb begin
        lk_a_hit = 1'b0;
        lk_a_idx = '0;
        lk_b_hit = 1'b0;
        lk_b_idx = '0;
        for (int i = N_ACCT - 1; i >= 0; i--) begin
            if (valid_tab[i] && (id_tab[i] == lk_a_id)) begin
                lk_a_hit = 1'b1;
                lk_a_idx = IDX_W'(i);
            end
            if (valid_tab[i] && (id_tab[i] == lk_b_id)) begin
                lk_b_hit = 1'b1;
                lk_b_idx = IDX_W'(i);
            end
        end
    end

    assign lk_a_lock = lock_tab[lk_a_idx];
    assign lk_b_bal  = bal_tab[lk_b_idx];
    assign rd_pin    = pin_tab[rd_idx];
    assign rd_bal    = bal_tab[rd_idx];

endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session FSM: card/PIN authentication, account operations, lockout and timeout
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int N_ACCT    = 4,
    parameter int ID_W      = 12,
    parameter int BAL_W     = 16,
    parameter int AMT_W     = 8,
    parameter int PIN_TRIES = 3,
    parameter int TIMEOUT   = 255
) (
    input logic          clk,
    input logic          rst,
    atm_session_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(N_ACCT);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int TRY_W = $clog2(PIN_TRIES + 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] cur_idx;
    logic [TRY_W-1:0] tries;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] amt_q;
    logic [ID_W-1:0]  dst_q;

    logic             a_hit, a_lock, b_hit;
    logic [IDX_W-1:0] a_idx, b_idx;
    logic [ID_W-1:0]  src_pin;
    logic [BAL_W-1:0] src_bal, dst_bal;

    logic             rsp_fire, lock_we, wr_a_en, wr_b_en;
    logic [3:0]       rsp_st_nx;
    logic [BAL_W-1:0] rsp_bal_nx, rsp_dst_nx, wr_a_bal, wr_b_bal;

    logic [BAL_W-1:0] amt_ext, diff_a;
    logic [BAL_W:0]   sum_a, sum_b;
    logic             amt_zero, short_a, tmo_hit, last_try, activity;

    atm_account_bank #(.N_ACCT(N_ACCT), .ID_W(ID_W), .BAL_W(BAL_W)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (bus.cfg_we && (state == S_IDLE)),
        .cfg_idx  (bus.cfg_idx),
        .cfg_id   (bus.cfg_id),
        .cfg_pin  (bus.cfg_pin),
        .cfg_bal  (bus.cfg_bal),
        .lock_we  (lock_we),
        .lock_idx (cur_idx),
        .wr_a_en  (wr_a_en),
        .wr_a_idx (cur_idx),
        .wr_a_bal (wr_a_bal),
        .wr_b_en  (wr_b_en),
        .wr_b_idx (b_idx),
        .wr_b_bal (wr_b_bal),
        .lk_a_id  (bus.card_id),
        .lk_a_hit (a_hit),
        .lk_a_idx (a_idx),
        .lk_a_lock(a_lock),
        .lk_b_id  (dst_q),
        .lk_b_hit (b_hit),
        .lk_b_idx (b_idx),
        .lk_b_bal (dst_bal),
        .rd_idx   (cur_idx),
        .rd_pin   (src_pin),
        .rd_bal   (src_bal)
    );

    assign amt_ext  = BAL_W'(amt_q);
    assign amt_zero = (amt_q == '0);
    assign short_a  = (amt_ext > src_bal);
    assign diff_a   = src_bal - amt_ext;
    assign sum_a    = {1'b0, src_bal} + {1'b0, amt_ext};
    assign sum_b    = {1'b0, dst_bal} + {1'b0, amt_ext};
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign last_try = ((32'(tries) + 32'd1) >= PIN_TRIES);
    assign activity = ((state == S_PIN) && bus.pin_valid) || ((state == S_MENU) && bus.op_valid);

    assign bus.op_ready       = (state == S_MENU);
    assign bus.session_active = (state == S_PIN) || (state == S_MENU) || (state == S_EXEC);

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // next state, response content and table write strobes
    always_comb begin
        state_nx   = state;
        rsp_fire   = 1'b0;
        rsp_st_nx  = RSP_OK;
        rsp_bal_nx = '0;
        rsp_dst_nx = '0;
        lock_we    = 1'b0;
        wr_a_en    = 1'b0;
        wr_a_bal   = src_bal;
        wr_b_en    = 1'b0;
        wr_b_bal   = dst_bal;
        case (state)
            S_IDLE: if (bus.card_valid) begin
                if (!a_hit)      begin rsp_fire = 1'b1; rsp_st_nx = RSP_NO_ACCOUNT; end
                else if (a_lock) begin rsp_fire = 1'b1; rsp_st_nx = RSP_LOCKED; end
                else             state_nx = S_PIN;
            end
            S_PIN: if (bus.pin_valid) begin
                if (bus.pin == src_pin) state_nx = S_MENU;
                else if (last_try) begin
                    lock_we = 1'b1; rsp_fire = 1'b1; rsp_st_nx = RSP_LOCKED; state_nx = S_IDLE;
                end else begin
                    rsp_fire = 1'b1; rsp_st_nx = RSP_BAD_PIN;
                end
            end else if (tmo_hit) begin
                rsp_fire = 1'b1; rsp_st_nx = RSP_TIMEOUT; state_nx = S_IDLE;
            end
            S_MENU: if (bus.op_valid) state_nx = S_EXEC;
                else if (tmo_hit) begin
                    rsp_fire = 1'b1; rsp_st_nx = RSP_TIMEOUT; state_nx = S_IDLE;
                end
            S_EXEC: begin
                rsp_fire   = 1'b1;
                rsp_bal_nx = src_bal;
                state_nx   = S_DONE;
                case (op_q)
                    OP_DEPOSIT:
                        if (amt_zero)         rsp_st_nx = RSP_BAD_AMOUNT;
                        else if (sum_a[BAL_W]) rsp_st_nx = RSP_OVERFLOW;
                        else begin
                            wr_a_en = 1'b1; wr_a_bal = sum_a[BAL_W-1:0]; rsp_bal_nx = sum_a[BAL_W-1:0];
                        end
                    OP_WITHDRAW:
                        if (amt_zero)     rsp_st_nx = RSP_BAD_AMOUNT;
                        else if (short_a) rsp_st_nx = RSP_INSUFFICIENT;
                        else begin
                            wr_a_en = 1'b1; wr_a_bal = diff_a; rsp_bal_nx = diff_a;
                        end
                    OP_BALANCE: rsp_st_nx = RSP_OK;
                    OP_TRANSFER:
                        if (!b_hit) rsp_st_nx = RSP_NO_ACCOUNT;
                        else begin
                            rsp_dst_nx = dst_bal;
                            if ((b_idx == cur_idx) || amt_zero) rsp_st_nx = RSP_BAD_AMOUNT;
                            else if (short_a)                   rsp_st_nx = RSP_INSUFFICIENT;
                            else if (sum_b[BAL_W])              rsp_st_nx = RSP_OVERFLOW;
                            else begin
                                // both legs commit on the same edge or not at all
                                wr_a_en = 1'b1; wr_a_bal = diff_a;
                                wr_b_en = 1'b1; wr_b_bal = sum_b[BAL_W-1:0];
                                rsp_bal_nx = diff_a; rsp_dst_nx = sum_b[BAL_W-1:0];
                            end
                        end
                    OP_EXIT: state_nx = S_IDLE;
                    default: rsp_st_nx = RSP_BAD_OP;
                endcase
            end
            S_DONE:  state_nx = S_MENU;
            default: state_nx = S_IDLE;
        endcase
    end

    // session context, timeout counter, captured operation and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_idx             <= '0;
            tries               <= '0;
            tmo_cnt             <= '0;
            op_q                <= '0;
            amt_q               <= '0;
            dst_q               <= '0;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_status      <= '0;
            bus.rsp_balance     <= '0;
            bus.rsp_dst_balance <= '0;
            bus.locked          <= 1'b0;
        end else begin
            bus.rsp_valid <= rsp_fire;
            bus.locked    <= rsp_fire && (rsp_st_nx == RSP_LOCKED);
            if (rsp_fire) begin
                bus.rsp_status      <= rsp_st_nx;
                bus.rsp_balance     <= rsp_bal_nx;
                bus.rsp_dst_balance <= rsp_dst_nx;
            end
            if ((state == S_IDLE) && bus.card_valid && a_hit) begin
                cur_idx <= a_idx;
                tries   <= '0;
            end
            if ((state == S_PIN) && bus.pin_valid && (bus.pin != src_pin))
                tries <= tries + 1'b1;
            if ((state == S_MENU) && bus.op_valid) begin
                op_q  <= bus.op;
                amt_q <= bus.amount;
                dst_q <= bus.dst_id;
            end
            if ((state_nx != state) || activity)
                tmo_cnt <= '0;
            else if ((state == S_PIN) || (state == S_MENU))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule
